// File: rtl/itr_ctrl_if.sv
// rtl/itr_ctrl_if.sv - core IO bus bundle shared by the core and the interrupt controller
//
// Signals:
//   req_in    core IO read strobe
//   addr_in   core IO read address
//   out_en    core IO write strobe
//   addr_out  core IO write address
//   data_out  core IO write data
//   rd_data   read data returned to the core's io_in mux
//   rd_sel    rd_data selected for the current read
// Modports: master = core side, slave = peripheral side.
interface itr_ctrl_if #(
  parameter int NUBITS = 32,
  parameter int NADDR  = 3
);
  logic              req_in;
  logic [NADDR-1:0]  addr_in;
  logic              out_en;
  logic [NADDR-1:0]  addr_out;
  logic [NUBITS-1:0] data_out;
  logic [NUBITS-1:0] rd_data;
  logic              rd_sel;

  modport master (
    output req_in, addr_in, out_en, addr_out, data_out,
    input  rd_data, rd_sel
  );

  modport slave (
    input  req_in, addr_in, out_en, addr_out, data_out,
    output rd_data, rd_sel
  );
endinterface

// File: rtl/itr_ctrl.sv
// rtl/itr_ctrl.sv - fixed-priority interrupt controller driving the core's single itr input
//
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   irq       request lines, rising-edge sensitive
//   hold      core inhibit; blocks a new itr while high
//   io        core IO bus (slave side): vector/status reads, mask/EOI writes
//   itr       registered one-cycle interrupt pulse
//   active    an interrupt is in flight
// Optional: define ITR_WDOG_EN to build the ACK/SRV watchdog (limit WDOGCY cycles).
module itr_ctrl #(
  parameter int NIRQ   = 4,
  parameter int NUBITS = 32,
  parameter int NADDR  = 3,
  parameter int VECADD = 0,
  parameter int STSADD = 1,
  parameter int MSKADD = 0,
  parameter int EOIADD = 1,
  parameter int WDOGCY = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            hold,
  itr_ctrl_if.slave       io,
  output logic            itr,
  output logic            active
);
  localparam int VW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {IDLE, FIRE, ACK, SRV} state_t;

  state_t          state, state_n;
  logic [NIRQ-1:0] irq_q, pending, mask, rise, eligible, clr;
  logic [VW-1:0]   vec, winner;
  logic            itr_n, wdog;
  logic            vec_rd, msk_wr, eoi_wr;

`ifdef ITR_WDOG_EN
  localparam int CW = $clog2(WDOGCY + 1);
  logic [CW-1:0] wcnt;
  logic          timeout, sts_rd;
  assign sts_rd = io.req_in && (io.addr_in == NADDR'(STSADD));
`endif

  // Only the low NIRQ bits of a mask write carry meaning.
  wire unused_data = &{1'b0, io.data_out[NUBITS-1:NIRQ]};

  assign rise     = irq & ~irq_q;
  assign eligible = pending & mask;
  assign vec_rd   = io.req_in && (io.addr_in == NADDR'(VECADD));
  assign msk_wr   = io.out_en && (io.addr_out == NADDR'(MSKADD));
  assign eoi_wr   = io.out_en && (io.addr_out == NADDR'(EOIADD));
  assign active   = (state != IDLE);

  // Lowest set index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = VW'(i);
    end
  end

  always_comb begin
    state_n = state;
    itr_n   = 1'b0;
    clr     = '0;
`ifdef ITR_WDOG_EN
    timeout = 1'b0;
`endif
    case (state)
      IDLE: if (|eligible && !hold) begin
        state_n = FIRE;
        itr_n   = 1'b1;
      end
      FIRE: state_n = ACK;
      ACK: begin
        // An EOI before the vector read is spurious: drop the ISR, keep the request.
        if (eoi_wr) state_n = IDLE;
        else if (vec_rd) begin
          clr[vec] = 1'b1;
          state_n  = SRV;
        end
      end
      SRV: if (eoi_wr) state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef ITR_WDOG_EN
    // Fires only when the cycle carried no handshake; >= also covers an
    // acknowledge landing on the very last ACK cycle.
    if ((state == ACK || state == SRV) && state_n == state && wcnt >= CW'(WDOGCY - 1)) begin
      timeout = 1'b1;
      state_n = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      itr     <= 1'b0;
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
      vec     <= '0;
    end else begin
      itr   <= itr_n;
      irq_q <= irq;
      // A fresh rise outranks the acknowledge clear on the same line.
      pending <= (pending & ~clr) | rise;
      if (msk_wr) mask <= io.data_out[NIRQ-1:0];
      if (itr_n)  vec  <= winner;
    end
  end

`ifdef ITR_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      wdog <= 1'b0;
    end else begin
      if (state == FIRE) wcnt <= '0;
      else if (state == ACK || state == SRV) wcnt <= wcnt + 1'b1;
      if (timeout)     wdog <= 1'b1;
      else if (sts_rd) wdog <= 1'b0;
    end
  end
`else
  assign wdog = 1'b0;
`endif

  assign io.rd_sel = io.req_in &&
                     (io.addr_in == NADDR'(VECADD) || io.addr_in == NADDR'(STSADD));

  always_comb begin
    io.rd_data = '0;
    if (io.addr_in == NADDR'(VECADD))      io.rd_data = NUBITS'(vec);
    else if (io.addr_in == NADDR'(STSADD)) io.rd_data = NUBITS'({wdog, active, pending});
  end
endmodule
